// File: rtl/mips_cpu_top.sv
// Single-cycle MIPS-subset CPU: 32-word instruction memory (side-band loaded),
// 32x32 register file, 32-word data memory. Fetch, decode, execute, memory
// access and writeback all settle combinationally within one clock; PC,
// register file and data memory update on the rising edge.
//
// Load port: there is no handshake. Every rising edge with load_mem_en=1
// writes load_mem_data into imem[load_mem_addr], whether or not reset is
// asserted. While load_mem_en=1 the core is stalled: the PC holds and no
// register or data-memory write happens.
module mips_cpu_top #(
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_mem_en,
  input  logic [31:0] load_mem_data,
  input  logic [4:0]  load_mem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DMEM_DEPTH];
  logic [31:0] pc_q, pc_d;

  logic        run;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, sext_imm, zext_imm, pc_plus4;
  logic [31:0] alu_res, wb_val, dmem_rdata, next_pc;
  logic [4:0]  dest;
  logic        reg_write, mem_read, mem_write;
  logic        rf_we, dmem_we;

  // The core only advances when out of reset and not being loaded.
  assign run = rst_n & ~load_mem_en;

  // Fetch uses PC[6:2] only, so the program wraps every 128 bytes.
  assign instr    = imem_q[pc_q[6:2]];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};
  assign pc_plus4 = pc_q + 32'd4;

  // Register $0 reads as zero; reads see the pre-edge value.
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  // Data memory is word indexed by address bits [6:2]; others are ignored.
  assign dmem_rdata = dmem_q[alu_res[6:2]];

  // Decode and execute: ALU result, destination, memory controls, next PC.
  always_comb begin
    alu_res   = 32'd0;
    dest      = 5'd0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    next_pc   = pc_plus4;
    case (op)
      OP_RTYPE: begin
        dest = rd;
        reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_res = rs_val + rt_val;
          FN_SUB:  alu_res = rs_val - rt_val;
          FN_AND:  alu_res = rs_val & rt_val;
          FN_OR:   alu_res = rs_val | rt_val;
          FN_SLT:  alu_res = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
          FN_SLL:  alu_res = rt_val << shamt;
          default: reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_res = rs_val + sext_imm;
        dest = rt;
        reg_write = 1'b1;
      end
      OP_ANDI: begin
        alu_res = rs_val & zext_imm;
        dest = rt;
        reg_write = 1'b1;
      end
      OP_ORI: begin
        alu_res = rs_val | zext_imm;
        dest = rt;
        reg_write = 1'b1;
      end
      OP_LW: begin
        alu_res = rs_val + sext_imm;
        dest = rt;
        reg_write = 1'b1;
        mem_read = 1'b1;
      end
      OP_SW: begin
        alu_res = rs_val + sext_imm;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        if (rs_val == rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
      end
      OP_BNE: begin
        if (rs_val != rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
      end
      OP_J: begin
        next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end
      default: ;
    endcase
  end

  // Writeback selection, write enables gated by run, and PC hold on stall.
  always_comb begin
    wb_val  = mem_read ? dmem_rdata : alu_res;
    rf_we   = run & reg_write & (dest != 5'd0);
    dmem_we = run & mem_write;
    pc_d    = pc_q;
    if (run) pc_d = next_pc;
  end

  // Instruction memory load port; never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_mem_en) imem_q[load_mem_addr] <= load_mem_data;
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= 32'd0;
    else        pc_q <= pc_d;
  end

  // Register file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (rf_we) begin
      rf_q[dest] <= wb_val;
    end
  end

  // Data memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 32'd0;
    end else if (dmem_we) begin
      dmem_q[alu_res[6:2]] <= rt_val;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr;
  assign wb_en     = rf_we;
  assign wb_addr   = rf_we ? dest : 5'd0;
  assign wb_data   = rf_we ? wb_val : 32'd0;

endmodule

// File: tb/tb_mips_cpu_top.sv
// Bench for mips_cpu_top: an instruction-level reference model (architectural
// registers, memories and PC) is compared against the DUT every cycle, with
// directed programs carrying hand-computed expectations plus random programs.
module tb_mips_cpu_top;

  logic        clk;
  logic        rst_n;
  logic        load_mem_en;
  logic [31:0] load_mem_data;
  logic [4:0]  load_mem_addr;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  logic [31:0] m_imem [32];
  bit          m_loaded [32];
  logic [31:0] m_rf [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_pc;
  logic [31:0] prog [32];

  mips_cpu_top dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_mem_en   (load_mem_en),
    .load_mem_data (load_mem_data),
    .load_mem_addr (load_mem_addr),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural effect of the instruction at m_pc on the current model state.
  task automatic model_eval(output bit we, output logic [4:0] wa, output logic [31:0] wd,
                            output logic [31:0] npc, output bit mwe,
                            output logic [4:0] ma, output logic [31:0] md);
    logic [31:0] ins, a, b, se, pc4, addr;
    ins  = m_imem[m_pc[6:2]];
    a    = m_rf[ins[25:21]];
    b    = m_rf[ins[20:16]];
    se   = {{16{ins[15]}}, ins[15:0]};
    pc4  = m_pc + 32'd4;
    addr = a + se;
    npc = pc4; we = 0; wa = 0; wd = 0; mwe = 0; ma = 0; md = 0;
    case (ins[31:26])
      6'h00: begin
        we = 1; wa = ins[15:11];
        case (ins[5:0])
          6'h20: wd = a + b;
          6'h22: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: wd = b << ins[10:6];
          default: we = 0;
        endcase
      end
      6'h08: begin we = 1; wa = ins[20:16]; wd = a + se; end
      6'h0C: begin we = 1; wa = ins[20:16]; wd = a & {16'h0, ins[15:0]}; end
      6'h0D: begin we = 1; wa = ins[20:16]; wd = a | {16'h0, ins[15:0]}; end
      6'h23: begin we = 1; wa = ins[20:16]; wd = m_dmem[(addr % 128) / 4]; end
      6'h2B: begin mwe = 1; ma = 5'((addr % 128) / 4); md = b; end
      6'h04: if (a == b) npc = pc4 + se * 4;
      6'h05: if (a != b) npc = pc4 + se * 4;
      6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (wa == 5'd0) we = 0;
    if (!we) begin wa = 0; wd = 0; end
  endtask

  always @(posedge clk) begin
    if (load_mem_en) begin
      m_imem[load_mem_addr]   <= load_mem_data;
      m_loaded[load_mem_addr] <= 1'b1;
    end
  end

  bit          u_we, u_mwe;
  logic [4:0]  u_wa, u_ma;
  logic [31:0] u_wd, u_npc, u_md;
  always @(posedge clk) begin
    if (rst_n && !load_mem_en) begin
      model_eval(u_we, u_wa, u_wd, u_npc, u_mwe, u_ma, u_md);
      if (u_we)  m_rf[u_wa]   <= u_wd;
      if (u_mwe) m_dmem[u_ma] <= u_md;
      m_pc <= u_npc;
    end
  end

  always @(negedge rst_n) begin
    m_pc <= 32'd0;
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   <= 32'd0;
      m_dmem[i] <= 32'd0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          c_we, c_mwe, c_exp_en;
  logic [4:0]  c_wa, c_ma;
  logic [31:0] c_wd, c_npc, c_md;
  always @(negedge clk) begin
    if (chk_on) begin
      model_eval(c_we, c_wa, c_wd, c_npc, c_mwe, c_ma, c_md);
      c_exp_en = rst_n && !load_mem_en && c_we;
      chk("pc_out", pc_out, m_pc);
      if (m_loaded[m_pc[6:2]]) chk("instr_out", instr_out, m_imem[m_pc[6:2]]);
      chk("wb_en", {31'd0, wb_en}, {31'd0, c_exp_en});
      if (c_exp_en) begin
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, c_wa});
        chk("wb_data", wb_data, c_wd);
      end else if (!rst_n) begin
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) begin
      load_mem_en   = 1'b1;
      load_mem_addr = i[4:0];
      load_mem_data = prog[i];
      tick();
    end
    load_mem_en = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    int off;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    off = int'($urandom_range(0, 16)) - 8;
    case ($urandom_range(0, 14))
      0:  return enc_r(6'h20, a, b, c, 5'd0);
      1:  return enc_r(6'h22, a, b, c, 5'd0);
      2:  return enc_r(6'h24, a, b, c, 5'd0);
      3:  return enc_r(6'h25, a, b, c, 5'd0);
      4:  return enc_r(6'h2A, a, b, c, 5'd0);
      5:  return enc_r(6'h00, a, 5'd0, c, 5'($urandom_range(0, 31)));
      6:  return enc_i(6'h08, a, b, 16'($urandom));
      7:  return enc_i(6'h0C, a, b, 16'($urandom));
      8:  return enc_i(6'h0D, a, b, 16'($urandom));
      9:  return enc_i(6'h23, a, b, 16'(off * 3));
      10: return enc_i(6'h2B, a, b, 16'(off * 3));
      11: return enc_i(6'h04, a, b, 16'((off / 2 == -1) ? 2 : off / 2));
      12: return enc_i(6'h05, a, b, 16'((off / 2 == -1) ? 2 : off / 2));
      13: return {6'h02, 26'($urandom_range(0, 31))};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] arith_exp [5];

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_imem[i] = 32'd0; m_loaded[i] = 0; m_rf[i] = 32'd0; m_dmem[i] = 32'd0;
    end
    m_pc = 32'd0;
    rst_n = 1'b1; load_mem_en = 1'b0; load_mem_addr = 5'd0; load_mem_data = 32'd0;
    #2 rst_n = 1'b0;
    chk_on = 1;
    #1;
    chk("reset_pc", pc_out, 32'd0);
    chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Arithmetic program, loaded while out of reset (core stalled).
    for (int i = 0; i < 32; i++) prog[i] = 32'd0;
    prog[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    prog[1] = enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD);
    prog[2] = enc_r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0);
    prog[3] = enc_r(6'h22, 5'd4, 5'd1, 5'd2, 5'd0);
    prog[4] = enc_r(6'h2A, 5'd5, 5'd2, 5'd1, 5'd0);
    arith_exp[0] = 32'd5; arith_exp[1] = 32'hFFFF_FFFD; arith_exp[2] = 32'd2;
    arith_exp[3] = 32'd8; arith_exp[4] = 32'd1;
    load_prog();
    chk("load_pc_held", pc_out, 32'd0);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (k < 5) begin
        chk("arith_wb_en", {31'd0, wb_en}, 32'd1);
        chk("arith_wb_addr", {27'd0, wb_addr}, 32'(k + 1));
        chk("arith_wb_data", wb_data, arith_exp[k]);
      end
      if (k == 32) begin
        chk("wrap_pc", pc_out, 32'h80);
        chk("wrap_wb_data", wb_data, 32'd5);
      end
    end
    chk("model_r3", m_rf[3], 32'd2);
    chk("model_r4", m_rf[4], 32'd8);

    // Memory/branch program, loaded while held in reset.
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(6'h08, 5'd1, 5'd0, 16'h1234);
    prog[1]  = enc_i(6'h2B, 5'd1, 5'd0, 16'd8);
    prog[2]  = enc_i(6'h23, 5'd6, 5'd0, 16'd8);
    prog[3]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    prog[4]  = enc_i(6'h08, 5'd7, 5'd0, 16'd1);
    prog[5]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    prog[6]  = enc_i(6'h08, 5'd9, 5'd0, 16'd99);
    prog[7]  = enc_i(6'h08, 5'd9, 5'd0, 16'd99);
    prog[8]  = enc_i(6'h05, 5'd1, 5'd1, 16'd3);
    prog[9]  = 32'hFC00_0000;
    prog[10] = {6'h02, 26'd0};
    load_prog();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      case (k)
        0: chk("addi_wb_data", wb_data, 32'h1234);
        1: chk("sw_wb_en", {31'd0, wb_en}, 32'd0);
        2: begin
          chk("lw_wb_addr", {27'd0, wb_addr}, 32'd6);
          chk("lw_wb_data", wb_data, 32'h1234);
        end
        3: chk("r0_wb_en", {31'd0, wb_en}, 32'd0);
        4: chk("r0_reads_zero", wb_data, 32'd1);
        5: chk("beq_pc", pc_out, 32'h14);
        6: chk("beq_taken_pc", pc_out, 32'h20);
        7: begin
          chk("bne_not_taken_pc", pc_out, 32'h24);
          chk("bad_op_wb_en", {31'd0, wb_en}, 32'd0);
        end
        8: chk("j_pc", pc_out, 32'h28);
        9: chk("j_target_pc", pc_out, 32'd0);
        default: ;
      endcase
    end
    chk("model_r9", m_rf[9], 32'd0);
    chk("model_dmem2", m_dmem[2], 32'h1234);

    // Random programs with stall loads and an asynchronous mid-run reset.
    tick();
    for (int p = 0; p < 3; p++) begin
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) prog[i] = rand_instr();
      load_prog();
      rst_n = 1'b1;
      repeat (40) tick();
      for (int s = 0; s < 3; s++) begin
        load_mem_en   = 1'b1;
        load_mem_addr = 5'($urandom_range(0, 31));
        load_mem_data = rand_instr();
        tick();
      end
      load_mem_en = 1'b0;
      repeat (40) tick();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_pc", pc_out, 32'd0);
      chk("async_rst_wb_en", {31'd0, wb_en}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (60) tick();
    end

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
